// File: rtl/async_fifo_pkg.sv
// Shared pointer configuration and Gray/binary conversions for the async FIFO controllers.
package async_fifo_pkg;

    localparam int unsigned DEF_WIDTH     = 16;
    localparam int unsigned DEF_ADD_BUS   = 3;
    localparam int unsigned DEF_AF_THRESH = 6;
    localparam int unsigned PTR_W         = DEF_ADD_BUS + 1;

    // Zero-extend narrower pointers into these; the result is valid at any width up to 32.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/async_fifo_wr_ctrl_if.sv
// Write-side bundle: producer stream, RAM write port and the Gray pointers exchanged with the read side.
// The wr_level signal exists only when WR_LEVEL_EN is defined.
interface async_fifo_wr_ctrl_if #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned ADD_BUS = 3
);
    logic               wr_valid;
    logic [WIDTH-1:0]   wr_data;
    logic               wr_ready;
    logic               ram_we;
    logic [ADD_BUS-1:0] ram_w_add;
    logic [WIDTH-1:0]   ram_din;
    logic [ADD_BUS:0]   rd_ptr_gray;
    logic [ADD_BUS:0]   wr_ptr_gray;
    logic               full;
    logic               almost_full;
    logic               overflow_err;
`ifdef WR_LEVEL_EN
    logic [ADD_BUS:0]   wr_level;
`endif

    modport master (
        output wr_valid, wr_data, rd_ptr_gray,
        input  wr_ready, ram_we, ram_w_add, ram_din, wr_ptr_gray, full, almost_full, overflow_err
`ifdef WR_LEVEL_EN
        , input wr_level
`endif
    );

    modport slave (
        input  wr_valid, wr_data, rd_ptr_gray,
        output wr_ready, ram_we, ram_w_add, ram_din, wr_ptr_gray, full, almost_full, overflow_err
`ifdef WR_LEVEL_EN
        , output wr_level
`endif
    );
endinterface

// File: rtl/async_fifo_wr_ctrl_gray_ptr_sync.sv
// Two-flop synchroniser for a Gray pointer crossing into the local clock domain.
module gray_ptr_sync #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] q1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q1 <= '0;
            q  <= '0;
        end else begin
            q1 <= d;
            q  <= q1;
        end
    end
endmodule

// File: rtl/async_fifo_wr_ctrl.sv
// Async FIFO write-side controller: accepts the write stream, drives the RAM write port, flags full.
// Define WR_LEVEL_EN to add the registered wr_level occupancy output.
module async_fifo_wr_ctrl
    import async_fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned ADD_BUS   = DEF_ADD_BUS,
    parameter int unsigned AF_THRESH = DEF_AF_THRESH
) (
    input  logic                 w_clk,
    input  logic                 reset,
    async_fifo_wr_ctrl_if.slave  bus
);
    localparam int unsigned PW = ADD_BUS + 1;

    logic [PW-1:0] wr_bin;
    logic [PW-1:0] wr_bin_next;
    logic [PW-1:0] gray_next;
    logic [PW-1:0] rq2;
    logic [PW-1:0] rd_bin;
    logic [PW-1:0] occ_next;
    logic [PW-1:0] full_gray;
    logic [PW-1:0] wr_gray_q;
    logic          full_q;
    logic          af_q;
    logic          ovf_q;
    logic          accept;

    gray_ptr_sync #(.W(PW)) u_rd_sync (
        .clk   (w_clk),
        .reset (reset),
        .d     (bus.rd_ptr_gray),
        .q     (rq2)
    );

    // Next pointer and occupancy fold in this edge's accept and the latest synchronised read pointer.
    always_comb begin
        accept      = bus.wr_valid & ~full_q & ~reset;
        wr_bin_next = wr_bin + PW'(accept);
        gray_next   = PW'(bin2gray(32'(wr_bin_next)));
        rd_bin      = PW'(gray2bin(32'(rq2)));
        occ_next    = wr_bin_next - rd_bin;
        full_gray   = {~rq2[PW-1:PW-2], rq2[PW-3:0]};
    end

    always_ff @(posedge w_clk or posedge reset) begin
        if (reset) begin
            wr_bin    <= '0;
            wr_gray_q <= '0;
            full_q    <= 1'b0;
            af_q      <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            wr_bin    <= wr_bin_next;
            wr_gray_q <= gray_next;
            full_q    <= (gray_next == full_gray);
            af_q      <= (occ_next >= PW'(AF_THRESH));
            if (bus.wr_valid && full_q) begin
                ovf_q <= 1'b1;
            end
        end
    end

`ifdef WR_LEVEL_EN
    logic [PW-1:0] level_q;

    always_ff @(posedge w_clk or posedge reset) begin
        if (reset) begin
            level_q <= '0;
        end else begin
            level_q <= occ_next;
        end
    end

    assign bus.wr_level = level_q;
`endif

    assign bus.wr_ready     = ~full_q & ~reset;
    assign bus.ram_we       = accept;
    assign bus.ram_w_add    = wr_bin[ADD_BUS-1:0];
    assign bus.ram_din      = bus.wr_data;
    assign bus.wr_ptr_gray  = wr_gray_q;
    assign bus.full         = full_q;
    assign bus.almost_full  = af_q;
    assign bus.overflow_err = ovf_q;
endmodule
